cskip_serial_sub: RTL and testbench
===================================

// Module: cskip_serial_sub
// PURPOSE
//   Multi-cycle unsigned/two's-complement subtractor: diff = a - b, computed 4 bits per cycle
//   through a single carry-skip slice with a registered borrow chain.
//   Inverse-direction companion to the team's 4-bit carry-skip adder. Used where a wide
//   subtract is needed at low area and a few cycles of latency are acceptable.
//   Valid/ready on both input and output sides.
// PARAMETERS
//   WIDTH   16   operand/result width. Must be a multiple of 4; any other value is an elaboration error.
//   NSLICE  WIDTH/4 (localparam)   number of slice iterations per operation.
// PORTS
//   clk        in   1      rising-edge clock, the only clock.
//   rst_n      in   1      asynchronous, active-low reset.
//   in_valid   in   1      operands a/b are valid.
//   in_ready   out  1      block accepts operands. Equals (state==IDLE), combinational.
//   a          in   WIDTH  minuend. Sampled only on the input handshake.
//   b          in   WIDTH  subtrahend. Sampled only on the input handshake.
//   out_valid  out  1      diff/borrow/overflow are valid.
//   out_ready  in   1      downstream consumes the result.
//   diff       out  WIDTH  a - b, mod 2^WIDTH.
//   borrow     out  1      1 iff a < b (unsigned). Equals the inverted final carry.
//   overflow   out  1      signed overflow: (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]).
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, slice count=0, diff=0, borrow=0, overflow=0, out_valid=0.
//     in_ready=1 while in reset. Any operation in flight is abandoned; no partial result is emitted.
//   FSM has three states: IDLE, RUN, DONE.
//   IDLE:
//     in_valid && in_ready at edge E0 -> latch a, ~b, carry=1, cnt=0; go to RUN.
//   RUN (one slice per cycle):
//     - {c_out, s} = a[4k+:4] + ~b[4k+:4] + carry, with k=cnt.
//     - Write s into diff[4k+:4]; carry <= c_out; cnt++.
//     - The slice is carry-skip: if all four bit-propagates are 1, c_out = carry-in via the skip mux.
//     - At edge E_NSLICE (last slice): go to DONE and set out_valid=1.
//       borrow = ~c_out. overflow is computed from the latched MSBs and the final diff[MSB].
//   Latency: out_valid is first high in the cycle after edge E_NSLICE, i.e. NSLICE cycles after acceptance.
//   DONE:
//     - Hold diff/borrow/overflow/out_valid stable until out_ready.
//     - out_valid && out_ready -> out_valid=0; go to IDLE.
//     - diff/borrow/overflow keep their last values until the next operation overwrites them.
//   No overlap:
//     - in_ready=0 in RUN and DONE; in_valid is ignored there.
//     - Earliest next accept is the cycle after the output handshake.
//     - Peak throughput is one result per NSLICE+2 cycles.
//   Changes on a/b after acceptance have no effect on the running operation.
//   out_ready asserted outside DONE has no effect.
//   While a handshake-side signal is undriven or X, behaviour is undefined; the bench keeps them known.
// STRUCTURE
//   Package cskip_pkg holds:
//     - localparam SLICE_W = 4.
//     - typedef enum logic [1:0] {IDLE, RUN, DONE} cskip_state_t.
//   Sub-module cskip_sub_slice, purely combinational:
//     - inputs a[3:0], bn[3:0], cin; outputs s[3:0], cout.
//     - Ripple of four full adders.
//     - Group propagate P = &(a ^ bn); cout = P ? cin : ripple_cout.
//   Top level holds:
//     - FSM; slice counter, $clog2(NSLICE)+1 bits.
//     - Operand registers; diff register; carry flop.
//     - Slice-select muxes and a one-hot slice write-enable into diff.
// TESTING (WIDTH=16 unless noted; NSLICE=4)
//   1. a=0x1234, b=0x0234
//      -> diff=0x1000, borrow=0, overflow=0.
//      out_valid high exactly 4 cycles after the accept edge.
//   2. a=0x0000, b=0x0001
//      -> diff=0xFFFF, borrow=1, overflow=0 (borrow ripples through every slice).
//   3. a=0x8000, b=0x0001
//      -> diff=0x7FFF, borrow=0, overflow=1.
//      Then a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow=1, overflow=1.
//   4. Skip path: a=0x5555, b=0x5555 (every slice fully propagating)
//      -> diff=0x0000, borrow=0.
//      Assert that the skip mux selected cin in all 4 slices.
//   5. Backpressure: hold out_ready=0 for 10 cycles after out_valid.
//      -> diff/borrow/overflow stable, in_ready=0, a second in_valid pulse ignored.
//      Then out_ready=1 -> IDLE, and the next op is accepted one cycle later with a correct result.
//   6. Reset mid-op: assert rst_n=0 asynchronously during RUN with cnt=2.
//      -> out_valid=0, diff=0, in_ready=1 immediately, without waiting for a clock edge.
//      After release, a=0xFFFF, b=0x0001 -> diff=0xFFFE, borrow=0.

Source files
------------

// File: rtl/cskip_pkg.sv
// cskip_pkg: shared slice width and FSM state encoding for the serial carry-skip subtractor
package cskip_pkg;
  localparam int SLICE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} cskip_state_t;
endpackage

// File: rtl/cskip_sub_slice.sv
// cskip_sub_slice: 4-bit ripple adder of a + bn + cin with a group-propagate skip on the carry out
module cskip_sub_slice
  import cskip_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] bn,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);
  logic [SLICE_W:0] c;
  logic             p;
  assign c[0] = cin;
  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ bn[i] ^ c[i];
    assign c[i+1] = (a[i] & bn[i]) | ((a[i] ^ bn[i]) & c[i]);
  end
  assign p    = &(a ^ bn);
  assign cout = p ? cin : c[SLICE_W];
endmodule

// File: rtl/cskip_serial_sub.sv
// cskip_serial_sub: a - b computed one 4-bit carry-skip slice per cycle with a registered borrow chain
module cskip_serial_sub
  import cskip_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = $clog2(NSLICE) + 1;
  if (WIDTH % SLICE_W != 0) begin : g_bad_width
    $error("cskip_serial_sub: WIDTH must be a multiple of 4");
  end
  cskip_state_t     state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, bn_q, diff_q, diff_d;
  logic             carry_q, borrow_q, ovf_q;
  logic [SLICE_W-1:0] sa, sbn, ss;
  logic             sc, last;
  assign last = cnt_q == CW'(NSLICE - 1);
  always_comb begin
    sa  = '0;
    sbn = '0;
    for (int k = 0; k < NSLICE; k++)
      if (cnt_q == CW'(k)) begin
        sa  = a_q[k*SLICE_W +: SLICE_W];
        sbn = bn_q[k*SLICE_W +: SLICE_W];
      end
  end
  cskip_sub_slice u_slice (.a(sa), .bn(sbn), .cin(carry_q), .s(ss), .cout(sc));
  always_comb begin
    diff_d = diff_q;
    for (int k = 0; k < NSLICE; k++)
      if (state_q == RUN && cnt_q == CW'(k)) diff_d[k*SLICE_W +: SLICE_W] = ss;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (in_valid ? RUN : IDLE) :
              state_q == RUN  ? (last ? DONE : RUN) :
                                (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
  end
  // b is stored inverted so each slice adds a + ~b with the chain seeded by carry=1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q    <= '0;
      a_q      <= '0;
      bn_q     <= '0;
      carry_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (in_valid && in_ready) begin
      a_q     <= a;
      bn_q    <= ~b;
      carry_q <= 1'b1;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      diff_q  <= diff_d;
      carry_q <= sc;
      cnt_q   <= cnt_q + 1'b1;
      if (last) begin
        borrow_q <= ~sc;
        ovf_q    <= (a_q[WIDTH-1] == bn_q[WIDTH-1]) && (ss[SLICE_W-1] != a_q[WIDTH-1]);
      end
    end
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_cskip_serial_sub.sv
// tb_cskip_serial_sub: directed self-checking bench for the serial carry-skip subtractor
module tb_cskip_serial_sub;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic [15:0] a, b;
  logic        in_ready, out_valid, borrow, overflow;
  logic [15:0] diff;
  int          total = 0;
  int          bad = 0;
  always #5 clk = ~clk;
  cskip_serial_sub #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .overflow(overflow)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_valid(input string tag);
    int cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 4);
  endtask
  task automatic finish_op(input string tag, input logic [15:0] ed, input logic eb, input logic eo);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, borrow, eb);
    chk({tag, "_ovf"}, overflow, eo);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_vld_drop"}, out_valid, 0);
    chk({tag, "_rdy_back"}, in_ready, 1);
  endtask
  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_b,
                       input logic [15:0] ed, input logic eb, input logic eo);
    a = ta;
    b = tb_b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = ~ta;
    b = ~tb_b;
    chk({tag, "_busy"}, in_ready, 0);
    wait_valid(tag);
    finish_op(tag, ed, eb, eo);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("t1", 16'h1234, 16'h0234, 16'h1000, 0, 0);
    do_op("t2", 16'h0000, 16'h0001, 16'hFFFF, 1, 0);
    do_op("t3a", 16'h8000, 16'h0001, 16'h7FFF, 0, 1);
    do_op("t3b", 16'h7FFF, 16'hFFFF, 16'h8000, 1, 1);
    // skip path: every slice fully propagates, so each carry-out is the skipped carry-in
    a = 16'h5555; b = 16'h5555; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_skip_p%0d", k), dut.u_slice.p, 1);
      chk($sformatf("t4_cout%0d", k), dut.u_slice.cout, 1);
      @(negedge clk);
    end
    chk("t4_valid", out_valid, 1);
    finish_op("t4", 16'h0000, 0, 0);
    // backpressure with an ignored second request
    a = 16'h4000; b = 16'h1234; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid("t5");
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      a = 16'h0F0F; b = 16'h0101;
      @(negedge clk);
      chk($sformatf("t5_hold_diff%0d", i), diff, 16'h2DCC);
      if (i == 3 || i == 9) begin
        chk($sformatf("t5_hold_rdy%0d", i), in_ready, 0);
        chk($sformatf("t5_hold_vld%0d", i), out_valid, 1);
        chk($sformatf("t5_hold_b%0d", i), {borrow, overflow}, 0);
      end
    end
    in_valid = 1'b0;
    finish_op("t5", 16'h2DCC, 0, 0);
    do_op("t5next", 16'h0100, 16'h00FF, 16'h0001, 0, 0);
    // asynchronous reset in the middle of an operation
    a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_cnt2", dut.cnt_q, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", out_valid, 0);
    chk("t6_rst_diff", diff, 0);
    chk("t6_rst_rdy", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_no_partial", out_valid, 0);
    do_op("t6", 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
